uart_frame_ctrl: RTL and testbench

Command-frame controller behind the UART receive path. Pops bytes from the receive FIFO that the UART receiver fills, assembles fixed 5-byte frames (header, address, data high, data low, checksum), validates them, and issues one register write per good frame on a simple config-write bus. Bad checksums and inter-byte timeouts are dropped and counted; the block resynchronises on the next header byte.

---
 rtl/uart_ctrl_pkg.sv | 23 ++
 rtl/uart_byte_fetch.sv | 27 ++
 rtl/uart_frame_ctrl.sv | 119 +++++++++++
 tb/tb_uart_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command-frame controller: FSM states,
// error codes, the default header byte and a saturating counter helper.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam logic [7:0] HDR_BYTE_DFLT = 8'hAA;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Pop handshake for a non-show-ahead FIFO: one outstanding read at a time,
// data presented with byte_vld the cycle after the pop.
module uart_byte_fetch (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  input  logic       hold,
  output logic       fifo_rd_en,
  output logic       byte_vld,
  output logic [7:0] byte_out
);

  logic rd_pend;

  assign fifo_rd_en = !fifo_empty && !rd_pend && !hold;
  assign byte_vld   = rd_pend;
  assign byte_out   = fifo_dout;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= fifo_rd_en;
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles 5-byte command frames from the UART RX FIFO, validates the XOR
// checksum and inter-byte gap, and issues one config write per good frame.
module uart_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DFLT
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  output logic        err_pulse,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned     GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic               commit, commit_nxt, csum_bad, tmo_hit;
  logic               byte_vld;
  logic [7:0]         byte_data;
  logic [7:0]         addr_sh, dhi_sh, dlo_sh;
  logic [GAP_W-1:0]   gap_cnt;

  uart_byte_fetch u_fetch (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .hold      (commit),
    .fifo_rd_en(fifo_rd_en),
    .byte_vld  (byte_vld),
    .byte_out  (byte_data)
  );

  assign busy      = (state != HUNT);
  assign cfg_wr_en = commit;
  // A byte landing on the timeout cycle wins, hence the !byte_vld term.
  assign tmo_hit   = busy && !byte_vld && (gap_cnt == GAP_LAST);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    commit_nxt = 1'b0;
    csum_bad   = 1'b0;
    case (state)
      HUNT: if (byte_vld && byte_data == HDR_BYTE) state_nxt = ADDR;
      ADDR: if (byte_vld) state_nxt = DHI;
      DHI:  if (byte_vld) state_nxt = DLO;
      DLO:  if (byte_vld) state_nxt = CSUM;
      CSUM: if (byte_vld) begin
        state_nxt = HUNT;
        if (byte_data == (addr_sh ^ dhi_sh ^ dlo_sh)) commit_nxt = 1'b1;
        else                                          csum_bad   = 1'b1;
      end
      default: state_nxt = HUNT;
    endcase
    if (tmo_hit) state_nxt = HUNT;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // NOTE: the shadow bytes are a handful of flops, not a memory, so they
  // take the reset like every other register here.
  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      commit    <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= ERR_NONE;
      cfg_addr  <= '0;
      cfg_wdata <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      addr_sh   <= '0;
      dhi_sh    <= '0;
      dlo_sh    <= '0;
      gap_cnt   <= '0;
    end else begin
      commit    <= commit_nxt;
      err_pulse <= csum_bad || tmo_hit;

      if (byte_vld) begin
        case (state)
          ADDR:    addr_sh <= byte_data;
          DHI:     dhi_sh  <= byte_data;
          DLO:     dlo_sh  <= byte_data;
          default: ;
        endcase
      end

      if (commit_nxt) begin
        cfg_addr  <= addr_sh;
        cfg_wdata <= {dhi_sh, dlo_sh};
        frame_cnt <= sat_inc(frame_cnt);
      end

      if (csum_bad || tmo_hit) begin
        err_code <= csum_bad ? ERR_CSUM : ERR_TMO;
        err_cnt  <= sat_inc(err_cnt);
      end

      if (byte_vld || !busy) gap_cnt <= '0;
      else                   gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: behavioural FIFO, scoreboard of
// expected writes/errors, and checks of counters, timing and reset.
module tb_uart_frame_ctrl;

  localparam int         T   = 40;
  localparam logic [7:0] HDR = 8'hAA;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  code;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd_en, cfg_wr_en, err_pulse, busy;
  logic [7:0]  cfg_addr, frame_cnt, err_cnt;
  logic [15:0] cfg_wdata;
  logic [1:0]  err_code;

  logic [7:0] q[$];
  exp_t       sb[$];
  int total = 0, bad = 0;
  int cyc = 0, last_vld = 0, last_pop = 0, prev_wr = 0;
  int rd_viol = 0, space_viol = 0, overlap = 0;
  logic prev_pop = 1'b0, burst = 1'b0;
  logic [7:0] m_frames = 0, m_errs = 0;

  always #10 clk = ~clk;

  uart_frame_ctrl #(.TIMEOUT_CYC(T), .HDR_BYTE(HDR)) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then service the FIFO after the edge.
  task automatic step();
    logic pop;
    exp_t e;
    @(negedge clk);
    if (cfg_wr_en === 1'b1 && err_pulse === 1'b1) overlap++;
    if (fifo_rd_en === 1'b1 && (prev_pop || cfg_wr_en === 1'b1)) rd_viol++;
    if (cfg_wr_en === 1'b1) begin
      check("wr_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("wr_kind", e.is_wr, 1);
        check("wr_addr", cfg_addr, e.addr);
        check("wr_data", cfg_wdata, e.data);
        check("wr_latency", cyc - last_pop, 2);
      end
      if (burst && prev_wr != 0 && cyc - prev_wr != 11) space_viol++;
      prev_wr = cyc;
    end
    if (err_pulse === 1'b1) begin
      check("err_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("err_kind", e.is_wr, 0);
        check("err_code", err_code, e.code);
        if (e.cyc != 0) check("err_cycle", cyc, e.cyc);
      end
    end
    pop = (fifo_rd_en === 1'b1);
    prev_pop = pop;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && q.size() != 0) begin
      fifo_dout = q.pop_front();
      last_pop  = cyc - 1;
      last_vld  = cyc;
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic expect_err(input logic [1:0] code, input int at);
    exp_t e;
    e.is_wr = 1'b0; e.addr = '0; e.data = '0; e.code = code; e.cyc = at;
    sb.push_back(e);
    m_errs = sat(m_errs);
  endtask

  // Queue a full frame and what the controller should do with it.
  task automatic send_frame(input logic [7:0] a, h, l, c);
    exp_t e;
    push(HDR); push(a); push(h); push(l); push(c);
    if (c == (a ^ h ^ l)) begin
      e.is_wr = 1'b1; e.addr = a; e.data = {h, l}; e.code = 2'd0; e.cyc = 0;
      sb.push_back(e);
      m_frames = sat(m_frames);
    end else begin
      expect_err(2'd1, 0);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || sb.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_complete", q.size() + sb.size(), 0);
    repeat (3) step();
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt, m_frames);
    check({tag, "_err_cnt"}, err_cnt, m_errs);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_wr_en"}, cfg_wr_en, 0);
    check({tag, "_addr"}, cfg_addr, 0);
    check({tag, "_wdata"}, cfg_wdata, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_code"}, err_code, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int v;
    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Good frame
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    drain(200);
    check("good_addr_held", cfg_addr, 8'h12);
    check("good_wdata_held", cfg_wdata, 16'h3456);
    check_counts("good");

    // Bad checksum then a good frame; err_code holds the last error
    send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    drain(200);
    check("csum_err_code", err_code, 2'd1);
    check_counts("csum");
    send_frame(8'h01, 8'h00, 8'h02, 8'h03);
    drain(200);
    check("after_csum_addr", cfg_addr, 8'h01);
    check("after_csum_wdata", cfg_wdata, 16'h0002);
    check("after_csum_code_held", err_code, 2'd1);

    // Garbage before the header is dropped silently; AA inside a frame is data
    push(8'h00); push(8'hFF);
    send_frame(8'h05, 8'hAA, 8'h00, 8'hAF);
    drain(200);
    check("resync_wdata", cfg_wdata, 16'hAA00);
    check_counts("resync");

    // Timeout fires: trailing bytes land in HUNT and are discarded
    push(HDR); push(8'h12); push(8'h34);
    while (q.size() != 0) step();
    v = last_vld;
    check("busy_midframe", busy, 1);
    expect_err(2'd2, v + T + 1);
    while (cyc < v + T) step();
    push(8'h56); push(8'h70);
    drain(T + 100);
    check("tmo_err_code", err_code, 2'd2);
    check("tmo_busy_after", busy, 0);
    check_counts("tmo");

    // Byte arriving exactly on the timeout cycle keeps the frame alive
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    q.delete();
    push(HDR); push(8'h12); push(8'h34);
    while (q.size() != 0) step();
    v = last_vld;
    while (cyc < v + T - 1) step();
    push(8'h56); push(8'h70);
    step();
    check("edge_vld_cycle", last_vld, v + T);
    drain(T + 100);
    check("edge_addr", cfg_addr, 8'h12);
    check_counts("edge");

    // Reset mid-frame: header and address already popped
    push(HDR); push(8'h12);
    repeat (3) step();
    rst = 1'b1;
    m_frames = 0;
    m_errs   = 0;
    repeat (2) step();
    check_all_zero("midreset");
    rst = 1'b0;
    step();
    send_frame(8'h21, 8'hBE, 8'hEF, 8'h21 ^ 8'hBE ^ 8'hEF);
    drain(200);
    check("post_reset_addr", cfg_addr, 8'h21);
    check("post_reset_wdata", cfg_wdata, 16'hBEEF);
    check_counts("post_reset");

    // 300 back-to-back frames: saturation and 11-cycle spacing
    burst   = 1'b1;
    prev_wr = 0;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, h, l;
      a = 8'(i);
      h = 8'h5A ^ 8'(i >> 1);
      l = ~a;
      send_frame(a, h, l, a ^ h ^ l);
    end
    drain(300 * 11 + 200);
    burst = 1'b0;
    check("sat_frame_cnt", frame_cnt, 8'hFF);
    check_counts("burst");

    check("no_wr_err_overlap", overlap, 0);
    check("rd_en_blocking", rd_viol, 0);
    check("frame_spacing", space_viol, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
